cycle_tracker_4004: RTL

CYCLE_TRACKER_4004 -- requirements
Module: cycle_tracker_4004

---
 rtl/cycle_tracker_4004_if.sv | 30 +++
 rtl/cycle_tracker_4004.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/cycle_tracker_4004_if.sv
// rtl/cycle_tracker_4004_if.sv - core bus, ROM port and status bundle for the 4004 cycle tracker
interface cycle_tracker_4004_if;
  logic        clk1;
  logic        clk2;
  logic        reset;
  logic        sync;
  logic [3:0]  d_in;
  logic [3:0]  d_out;
  logic        d_oe;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic [2:0]  subcycle;
  logic        locked;
  logic        sync_err;
  logic        trace_valid;
  logic [11:0] trace_addr;
  logic [7:0]  trace_op;

  modport slave (
    input  clk1, clk2, reset, sync, d_in, rom_data,
    output d_out, d_oe, rom_addr, subcycle, locked, sync_err,
           trace_valid, trace_addr, trace_op
  );

  modport master (
    output clk1, clk2, reset, sync, d_in, rom_data,
    input  d_out, d_oe, rom_addr, subcycle, locked, sync_err,
           trace_valid, trace_addr, trace_op
  );
endinterface

// File: rtl/cycle_tracker_4004.sv
// rtl/cycle_tracker_4004.sv - 4004 subcycle tracker and ROM nibble server
// Optional fetch trace port enabled by CYCLE_TRACKER_4004_TRACE_EN.
module cycle_tracker_4004 #(
  parameter logic [3:0] CHIP_ID = 4'd0
) (
  input  logic                  eclk,
  input  logic                  ereset_n,
  cycle_tracker_4004_if.slave   bus
);

  typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

  localparam logic [2:0] SUB_A1 = 3'd0;
  localparam logic [2:0] SUB_A2 = 3'd1;
  localparam logic [2:0] SUB_A3 = 3'd2;
  localparam logic [2:0] SUB_M1 = 3'd3;
  localparam logic [2:0] SUB_M2 = 3'd4;
  localparam logic [2:0] SUB_X3 = 3'd7;

  state_t      state_q, state_d;
  logic        clk2_q;
  logic [2:0]  sub_q, sub_d;
  logic        err_q, err_d;
  logic [7:0]  addr_lo_q, addr_lo_d;
  logic [11:0] rom_addr_q, rom_addr_d;
  logic [1:0]  fetch_q, fetch_d;
  logic [7:0]  opcode_q, opcode_d;
  logic        oe_q, oe_d;
  logic [3:0]  dout_q, dout_d;
  logic        tick;

  assign tick = clk2_q & ~bus.clk2;

  always_comb begin
    state_d    = state_q;
    sub_d      = sub_q;
    err_d      = err_q;
    addr_lo_d  = addr_lo_q;
    rom_addr_d = rom_addr_q;
    opcode_d   = opcode_q;
    // fetch_q tracks the two-eclk ROM turnaround after a new address
    fetch_d    = {fetch_q[0], 1'b0};
    if (fetch_q[1]) begin
      opcode_d = bus.rom_data;
    end

    if (bus.reset) begin
      state_d = ST_UNLOCKED;
      sub_d   = SUB_X3;
      err_d   = 1'b0;
    end else if (tick && bus.clk1) begin
      err_d = 1'b1;
    end else if (tick) begin
      if (state_q == ST_UNLOCKED) begin
        if (bus.sync) begin
          state_d = ST_LOCKED;
          sub_d   = SUB_A1;
        end
      end else if (bus.sync && sub_q != SUB_X3) begin
        sub_d = SUB_A1;
        err_d = 1'b1;
      end else begin
        sub_d = sub_q + 3'd1;
        case (sub_q)
          SUB_A1: addr_lo_d[3:0] = bus.d_in;
          SUB_A2: addr_lo_d[7:4] = bus.d_in;
          SUB_A3: begin
            rom_addr_d = {bus.d_in, addr_lo_q};
            fetch_d[0] = 1'b1;
          end
          default: ;
        endcase
      end
    end

    oe_d   = (state_d == ST_LOCKED) && (sub_d == SUB_M1 || sub_d == SUB_M2) &&
             (rom_addr_d[11:8] == CHIP_ID);
    dout_d = 4'd0;
    if (oe_d) begin
      dout_d = (sub_d == SUB_M1) ? opcode_d[7:4] : opcode_d[3:0];
    end
  end

  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      state_q    <= ST_UNLOCKED;
      clk2_q     <= 1'b0;
      sub_q      <= SUB_X3;
      err_q      <= 1'b0;
      addr_lo_q  <= 8'd0;
      rom_addr_q <= 12'd0;
      fetch_q    <= 2'd0;
      opcode_q   <= 8'd0;
      oe_q       <= 1'b0;
      dout_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      clk2_q     <= bus.clk2;
      sub_q      <= sub_d;
      err_q      <= err_d;
      addr_lo_q  <= addr_lo_d;
      rom_addr_q <= rom_addr_d;
      fetch_q    <= fetch_d;
      opcode_q   <= opcode_d;
      oe_q       <= oe_d;
      dout_q     <= dout_d;
    end
  end

  assign bus.subcycle = sub_q;
  assign bus.locked   = (state_q == ST_LOCKED);
  assign bus.sync_err = err_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.d_oe     = oe_q;
  assign bus.d_out    = dout_q;

`ifdef CYCLE_TRACKER_4004_TRACE_EN
  logic        tv_q, tv_d;
  logic [11:0] taddr_q, taddr_d;
  logic [7:0]  top_q, top_d;

  // One record per served fetch, emitted as M2 closes
  always_comb begin
    tv_d    = 1'b0;
    taddr_d = taddr_q;
    top_d   = top_q;
    if (!bus.reset && tick && !bus.clk1 && state_q == ST_LOCKED &&
        sub_q == SUB_M2 && oe_q) begin
      tv_d    = 1'b1;
      taddr_d = rom_addr_q;
      top_d   = opcode_q;
    end
  end

  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      tv_q    <= 1'b0;
      taddr_q <= 12'd0;
      top_q   <= 8'd0;
    end else begin
      tv_q    <= tv_d;
      taddr_q <= taddr_d;
      top_q   <= top_d;
    end
  end

  assign bus.trace_valid = tv_q;
  assign bus.trace_addr  = taddr_q;
  assign bus.trace_op    = top_q;
`else
  assign bus.trace_valid = 1'b0;
  assign bus.trace_addr  = 12'd0;
  assign bus.trace_op    = 8'd0;
`endif

endmodule
